// File: rtl/channel_buffer_bram_16to256.sv
`default_nettype none
// ============================================================================
// Module      : channel_buffer_bram_16to256
// Description : Mixed-width simple dual-port sample buffer. Writes one narrow
//               word per cycle and reads a full line of LANES words per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_buffer_bram_16to256 #(
    parameter  int DATA_WIDTH = 16,
    parameter  int LANES      = 16,
    parameter  int RD_DEPTH   = 128,
    localparam int RD_AW      = $clog2(RD_DEPTH),
    localparam int LANE_AW    = $clog2(LANES),
    localparam int WR_AW      = RD_AW + LANE_AW,
    localparam int RD_WIDTH   = DATA_WIDTH * LANES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [WR_AW-1:0]      wraddress,
    input  logic                  wren,
    input  logic [RD_AW-1:0]      rdaddress,
    input  logic                  rden,
    output logic [RD_WIDTH-1:0]   q
);

    logic [RD_AW-1:0]   w_line;
    logic [LANE_AW-1:0] w_lane;

    assign w_line = wraddress[WR_AW-1:LANE_AW];
    assign w_lane = wraddress[LANE_AW-1:0];

    // One narrow bank per lane; the low write-address bits pick the bank so
    // the lowest address lands in the least significant slice of the line.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [LANE_AW-1:0] c_lane = LANE_AW'(i);

        logic [DATA_WIDTH-1:0] r_bank [RD_DEPTH] = '{default: '0};
        logic [DATA_WIDTH-1:0] r_lane_q;
        logic                  w_lane_we;

        assign w_lane_we = wren && (w_lane == c_lane);

        // Memory is deliberately outside the reset domain so contents persist.
        always_ff @(posedge clk) begin
            if (w_lane_we) begin
                r_bank[w_line] <= data;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_lane_q <= '0;
            end else if (rden) begin
                r_lane_q <= r_bank[rdaddress];
            end
        end

        assign q[i*DATA_WIDTH +: DATA_WIDTH] = r_lane_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_channel_buffer_bram_16to256.sv
`default_nettype none
// ============================================================================
// Module      : tb_channel_buffer_bram_16to256
// Description : Scoreboard bench for the 16-to-256 channel sample buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_buffer_bram_16to256;

    logic         clk;
    logic         rst_n;
    logic [15:0]  data;
    logic [10:0]  wraddress;
    logic         wren;
    logic [6:0]   rdaddress;
    logic         rden;
    logic [255:0] q;

    logic [255:0] sb [$];
    logic [255:0] got;
    logic [255:0] exp;
    int           n_pass;
    int           n_total;

    channel_buffer_bram_16to256 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .rden      (rden),
        .q         (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic write_word(input logic [10:0] addr, input logic [15:0] d);
        @(negedge clk);
        wraddress = addr;
        data      = d;
        wren      = 1'b1;
        @(posedge clk);
        #1;
        wren      = 1'b0;
    endtask

    // Drives a read and records its expected line; the caller compares.
    task automatic issue_read(input logic [6:0] addr, input logic [255:0] e);
        @(negedge clk);
        rdaddress = addr;
        rden      = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rden  = 1'b1;
        rdaddress = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (q !== 256'd0) $display("FAIL reset_q: got %h required %h", q, 256'd0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        rden  = 1'b0;
        issue_read(7'd0, 256'd0);
        got = q; exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL reset_read0: got %h required %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_lane_packing;
        logic [6:0]   lines [6];
        logic [255:0] exps  [6];
        write_word(11'd0,  16'h0001);
        write_word(11'd16, 16'h0002);
        write_word(11'd32, 16'h0003);
        write_word(11'd48, 16'h0004);
        write_word(11'd1,  16'h000A);
        write_word(11'd2,  16'h000B);
        lines = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd125, 7'd126};
        exps  = '{256'h000B_000A_0001, 256'h2, 256'h3, 256'h4, 256'd0, 256'd0};
        // Back-to-back reads: rden stays high across consecutive edges.
        for (int i = 0; i < 6; i++) begin
            issue_read(lines[i], exps[i]);
            got = q; exp = sb.pop_front(); n_total++;
            if (got !== exp) $display("FAIL packing_line%0d: got %h required %h", lines[i], got, exp);
            else n_pass++;
        end
        rden = 1'b0;
    endtask

    task automatic test_full_line;
        logic [255:0] e;
        e = '0;
        for (int k = 0; k < 16; k++) begin
            write_word(11'(2032 + k), 16'(k + 1));
            e[16*k +: 16] = 16'(k + 1);
        end
        issue_read(7'd127, e);
        got = q; exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL full_line127: got %h required %h", got, exp);
        else n_pass++;
        n_total++;
        if (q[255:240] !== 16'h0010) $display("FAIL top_lane: got %h required %h", q[255:240], 16'h0010);
        else n_pass++;
        rden = 1'b0;
    endtask

    task automatic test_read_during_write;
        @(negedge clk);
        wraddress = 11'd80;
        data      = 16'hBEEF;
        wren      = 1'b1;
        rdaddress = 7'd5;
        rden      = 1'b1;
        sb.push_back(256'd0);
        @(posedge clk);
        #1;
        wren = 1'b0;
        got = q; exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL rdw_old: got %h required %h", got, exp);
        else n_pass++;
        issue_read(7'd5, 256'hBEEF);
        got = q; exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL rdw_new: got %h required %h", got, exp);
        else n_pass++;
        rden = 1'b0;
    endtask

    task automatic test_hold_reset;
        logic [255:0] line0;
        line0 = 256'h000B_000A_0001;
        issue_read(7'd0, line0);
        got = q; exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL hold_pre: got %h required %h", got, exp);
        else n_pass++;
        @(negedge clk);
        rden = 1'b0;
        rdaddress = 7'd3;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (q !== line0) $display("FAIL hold: got %h required %h", q, line0);
        else n_pass++;
        // Reset with a read requested and a write pending: read suppressed, write kept.
        @(negedge clk);
        rst_n     = 1'b0;
        rden      = 1'b1;
        rdaddress = 7'd0;
        wraddress = 11'd49;
        data      = 16'h00C0;
        wren      = 1'b1;
        @(posedge clk);
        #1;
        wren = 1'b0;
        n_total++;
        if (q !== 256'd0) $display("FAIL reset_pulse_q: got %h required %h", q, 256'd0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        rden  = 1'b0;
        issue_read(7'd0, line0);
        got = q; exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL persist_line0: got %h required %h", got, exp);
        else n_pass++;
        issue_read(7'd3, 256'h00C0_0004);
        got = q; exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL write_in_reset: got %h required %h", got, exp);
        else n_pass++;
        rden = 1'b0;
    endtask

    task automatic test_overwrite;
        write_word(11'd1, 16'h1234);
        issue_read(7'd0, 256'h000B_1234_0001);
        got = q; exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL overwrite: got %h required %h", got, exp);
        else n_pass++;
        write_word(11'd1, 16'h5678);
        write_word(11'd1, 16'h9ABC);
        issue_read(7'd0, 256'h000B_9ABC_0001);
        got = q; exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL last_write_wins: got %h required %h", got, exp);
        else n_pass++;
        rden = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        data      = '0;
        wraddress = '0;
        wren      = 1'b0;
        rdaddress = '0;
        rden      = 1'b0;
        test_reset();
        test_lane_packing();
        test_full_line();
        test_read_during_write();
        test_hold_reset();
        test_overwrite();
        n_total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d required %0d", sb.size(), 0);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
